alu_share_arbiter: RTL and testbench

- Shares one combinational 16-bit ALU (3-bit function select, zero flag) between N_REQ requesters, e.g. the core datapath and a debug/multiply-assist unit.
- Requesters present operands and a function code with a valid/ready handshake. A round-robin arbiter picks one, registers its operands onto the ALU inputs, captures the result, and returns it tagged with the requester ID.
- Sits between the requesters and the single ALU instance. The ALU itself stays outside this block.

---
 rtl/alu_share_arbiter.sv | 141 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin front end that time-shares one external 16-bit ALU between
// N_REQ requesters and returns each captured result tagged with its owner's ID.
module alu_share_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [16*N_REQ-1:0] req_a,
  input  logic [16*N_REQ-1:0] req_b,
  input  logic [3*N_REQ-1:0]  req_op,
  output logic [15:0]         alu_a,
  output logic [15:0]         alu_b,
  output logic [2:0]          alu_control,
  input  logic [15:0]         alu_result,
  input  logic                alu_zero,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_id,
  output logic [15:0]         rsp_result,
  output logic                rsp_zero,
  output logic                busy
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           r_state;
  logic [PTR_W-1:0] r_rrPtr;
  logic [ID_W-1:0]  r_ownerId;
  logic [ID_W-1:0]  r_rspId;
  logic [15:0]      r_aluA;
  logic [15:0]      r_aluB;
  logic [2:0]       r_aluCtl;
  logic [15:0]      r_rspResult;
  logic             r_rspZero;
  logic             r_rspValid;
  logic             r_busy;

  logic             w_grantValid;
  logic [PTR_W-1:0] w_grantIdx;
  logic [PTR_W-1:0] w_nextPtr;
  logic [15:0]      w_selA;
  logic [15:0]      w_selB;
  logic [2:0]       w_selOp;

  // Scanning from the farthest offset down lets the nearest requester after r_rrPtr win.
  always_comb begin
    logic [PTR_W:0] w_sum;
    w_grantValid = 1'b0;
    w_grantIdx   = '0;
    w_sum        = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rrPtr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(N_REQ)) begin
        w_sum = w_sum - (PTR_W+1)'(N_REQ);
      end
      if (req_valid[w_sum[PTR_W-1:0]]) begin
        w_grantValid = 1'b1;
        w_grantIdx   = w_sum[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    w_selA    = '0;
    w_selB    = '0;
    w_selOp   = '0;
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grantIdx == PTR_W'(i)) begin
        w_selA       = req_a[16*i +: 16];
        w_selB       = req_b[16*i +: 16];
        w_selOp      = req_op[3*i +: 3];
        req_ready[i] = rst_n && w_grantValid && (r_state == IDLE);
      end
    end
  end

  assign w_nextPtr = (w_grantIdx == PTR_W'(N_REQ - 1)) ? '0 : w_grantIdx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rrPtr     <= '0;
      r_ownerId   <= '0;
      r_rspId     <= '0;
      r_aluA      <= '0;
      r_aluB      <= '0;
      r_aluCtl    <= '0;
      r_rspResult <= '0;
      r_rspZero   <= 1'b0;
      r_rspValid  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grantValid) begin
            r_aluA    <= w_selA;
            r_aluB    <= w_selB;
            r_aluCtl  <= w_selOp;
            r_ownerId <= ID_W'(w_grantIdx);
            r_rrPtr   <= w_nextPtr;
            r_busy    <= 1'b1;
            r_state   <= EXEC;
          end
        end
        EXEC: begin
          r_rspResult <= alu_result;
          r_rspZero   <= alu_zero;
          r_rspId     <= r_ownerId;
          r_rspValid  <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rspValid <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign alu_a       = r_aluA;
  assign alu_b       = r_aluB;
  assign alu_control = r_aluCtl;
  assign rsp_valid   = r_rspValid;
  assign rsp_id      = r_rspId;
  assign rsp_result  = r_rspResult;
  assign rsp_zero    = r_rspZero;
  assign busy        = r_busy;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: four requesters, a behavioural ALU,
// directed scenarios followed by a randomised phase.
module tb_alu_share_arbiter;
  localparam int N    = 4;
  localparam int ID_W = 3;

  typedef struct {
    int          id;
    logic [15:0] result;
    logic        zero;
    int          accCycle;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [16*N-1:0]   req_a;
  logic [16*N-1:0]   req_b;
  logic [3*N-1:0]    req_op;
  logic [15:0]       alu_a;
  logic [15:0]       alu_b;
  logic [2:0]        alu_control;
  logic [15:0]       alu_result;
  logic              alu_zero;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [15:0]       rsp_result;
  logic              rsp_zero;
  logic              busy;

  logic [15:0] tbA [N];
  logic [15:0] tbB [N];
  logic [2:0]  tbOp[N];
  logic [N-1:0] pend;

  int   checkCount = 0;
  int   passCount  = 0;
  int   cycleCount = 0;
  exp_t expQ[$];
  exp_t rspLog[$];
  int   acceptLog[$];
  int   acceptCyc[$];
  int   mdlPtr = 0;
  bit   inFlight = 1'b0;
  bit   seenValid = 1'b0;
  logic [N-1:0] grantedMask = '0;
  logic [15:0]  curA, curB;
  logic [2:0]   curOp;
  int           predW;
  logic [N-1:0] predReady;
  logic [15:0]  predRes;

  // Behavioural ALU: add, sub, and, or, xor, nor, shift-left, set-less-than.
  function automatic logic [15:0] aluFn(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return ~(a | b);
      3'b110:  return a << b[3:0];
      default: return (a < b) ? 16'd1 : 16'd0;
    endcase
  endfunction

  assign alu_result = aluFn(alu_a, alu_b, alu_control);
  assign alu_zero   = (alu_result == 16'd0);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[16*i +: 16] = tbA[i];
      req_b[16*i +: 16] = tbB[i];
      req_op[3*i +: 3]  = tbOp[i];
    end
  end

  alu_share_arbiter #(.N_REQ(N), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Reference model: rotating priority from the last grant, one transaction in flight at a time.
  always @(negedge clk) begin
    #3;
    if (!rst_n) begin
      mdlPtr      = 0;
      inFlight    = 1'b0;
      grantedMask = '0;
      expQ.delete();
    end else begin
      predW     = -1;
      predReady = '0;
      if (!inFlight) begin
        for (int k = 0; k < N; k++) begin
          if (predW < 0 && req_valid[(mdlPtr + k) % N]) predW = (mdlPtr + k) % N;
        end
      end
      if (predW >= 0) predReady[predW] = 1'b1;
      checkOutput("req_ready", 32'(req_ready), 32'(predReady));
      checkOutput("busy", 32'(busy), 32'(inFlight));
      if (inFlight) begin
        checkOutput("alu_a", 32'(alu_a), 32'(curA));
        checkOutput("alu_b", 32'(alu_b), 32'(curB));
        checkOutput("alu_control", 32'(alu_control), 32'(curOp));
      end
      grantedMask = req_ready & req_valid;
      if (predW >= 0) begin
        curA    = tbA[predW];
        curB    = tbB[predW];
        curOp   = tbOp[predW];
        predRes = aluFn(curA, curB, curOp);
        expQ.push_back('{id: predW, result: predRes, zero: (predRes == 16'd0),
                         accCycle: cycleCount});
        acceptLog.push_back(predW);
        acceptCyc.push_back(cycleCount);
        mdlPtr   = (predW + 1) % N;
        inFlight = 1'b1;
      end
    end
  end

  // Response monitor: every presented response must match the oldest outstanding prediction.
  always @(negedge clk) begin
    #4;
    if (!rst_n) begin
      seenValid = 1'b0;
    end else if (rsp_valid) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_rsp: got id %0d result %0h, expected no response",
                 rsp_id, rsp_result);
      end else begin
        checkOutput("rsp_id", 32'(rsp_id), 32'(expQ[0].id));
        checkOutput("rsp_result", 32'(rsp_result), 32'(expQ[0].result));
        checkOutput("rsp_zero", 32'(rsp_zero), 32'(expQ[0].zero));
        if (!seenValid) checkOutput("rsp_latency", 32'(cycleCount - expQ[0].accCycle), 32'd2);
        seenValid = 1'b1;
        if (rsp_ready) begin
          rspLog.push_back('{id: int'(rsp_id), result: rsp_result, zero: rsp_zero,
                             accCycle: cycleCount});
          void'(expQ.pop_front());
          inFlight  = 1'b0;
          seenValid = 1'b0;
        end
      end
    end else if (expQ.size() > 0 && (cycleCount - expQ[0].accCycle) >= 2) begin
      checkCount++;
      $display("[TB] FAIL missing_rsp: got rsp_valid 0, expected 1 for id %0d", expQ[0].id);
    end
  end

  task automatic newOps(input int i);
    tbA[i]  = 16'($urandom);
    tbB[i]  = ($urandom_range(0, 3) == 0) ? tbA[i] : 16'($urandom);
    tbOp[i] = 3'($urandom);
  endtask

  task automatic present(input int i, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b);
    tbOp[i]   = op;
    tbA[i]    = a;
    tbB[i]    = b;
    pend[i]   = 1'b1;
    req_valid = pend;
  endtask

  // mode 0: random traffic, 1: every requester always requesting, 2: hold current requests.
  task automatic applyStimulus(input int mode);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (grantedMask[i]) begin
        pend[i] = (mode == 1);
        if (mode == 1) newOps(i);
      end else if (mode == 0) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          newOps(i);
        end else if (pend[i] && $urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
        end
      end
    end
    grantedMask = '0;
    if (mode == 0) rsp_ready = ($urandom_range(0, 3) != 0);
    req_valid = pend;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n     = 1'b0;
    pend      = '0;
    req_valid = '0;
    @(negedge clk);
    grantedMask = '0;
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_alu_a", 32'(alu_a), 32'd0);
    checkOutput("rst_alu_b", 32'(alu_b), 32'd0);
    checkOutput("rst_alu_control", 32'(alu_control), 32'd0);
    checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("rst_rsp_result", 32'(rsp_result), 32'd0);
    checkOutput("rst_rsp_zero", 32'(rsp_zero), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic waitAccepts(input int n, input int mode, input int limit);
    int t = 0;
    while (acceptLog.size() < n && t < limit) begin
      applyStimulus(mode);
      t++;
    end
    checkOutput("accept_timeout", 32'(acceptLog.size() >= n), 32'd1);
  endtask

  task automatic waitResponses(input int n, input int limit);
    int t = 0;
    while (rspLog.size() < n && t < limit) begin
      applyStimulus(2);
      t++;
    end
    checkOutput("response_timeout", 32'(rspLog.size() >= n), 32'd1);
  endtask

  task automatic waitRspValid(input int limit);
    int t = 0;
    while (!rsp_valid && t < limit) begin
      applyStimulus(2);
      t++;
    end
    checkOutput("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic checkRsp(input string tag, input int idx, input int id,
                          input logic [15:0] res, input logic zero);
    if (idx < rspLog.size()) begin
      checkOutput({tag, "_id"}, 32'(rspLog[idx].id), 32'(id));
      checkOutput({tag, "_result"}, 32'(rspLog[idx].result), 32'(res));
      checkOutput({tag, "_zero"}, 32'(rspLog[idx].zero), 32'(zero));
    end else begin
      checkCount++;
      $display("[TB] FAIL %s_missing: got %0d responses, expected more than %0d",
               tag, rspLog.size(), idx);
    end
  endtask

  initial begin
    int base;
    int nRsp;
    int t;
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    pend      = '0;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      tbA[i]  = '0;
      tbB[i]  = '0;
      tbOp[i] = '0;
    end
    resetDut();

    $display("[TB] reset during response");
    nRsp = rspLog.size();
    present(0, 3'b000, 16'd5, 16'd3);
    waitAccepts(1, 2, 10);
    waitRspValid(10);
    resetDut();
    repeat (4) applyStimulus(2);
    checkOutput("abort_no_rsp", 32'(rspLog.size()), 32'(nRsp));

    $display("[TB] single add");
    rsp_ready = 1'b1;
    base = acceptLog.size();
    nRsp = rspLog.size();
    present(0, 3'b000, 16'h0005, 16'h0003);
    waitAccepts(base + 1, 2, 10);
    waitResponses(nRsp + 1, 10);
    checkRsp("add", nRsp, 0, 16'h0008, 1'b0);

    $display("[TB] simultaneous requests");
    resetDut();
    rsp_ready = 1'b1;
    base = acceptLog.size();
    nRsp = rspLog.size();
    present(0, 3'b001, 16'd7, 16'd7);
    present(1, 3'b011, 16'h00F0, 16'h000F);
    waitAccepts(base + 2, 2, 20);
    waitResponses(nRsp + 2, 20);
    checkRsp("simul_first", nRsp, 0, 16'h0000, 1'b1);
    checkRsp("simul_second", nRsp + 1, 1, 16'h00FF, 1'b0);
    if (acceptCyc.size() >= base + 2)
      checkOutput("accept_spacing", 32'(acceptCyc[base+1] - acceptCyc[base]), 32'd3);

    $display("[TB] round-robin fairness");
    resetDut();
    rsp_ready = 1'b1;
    base = acceptLog.size();
    nRsp = rspLog.size();
    for (int i = 0; i < N; i++) newOps(i);
    pend      = '1;
    req_valid = pend;
    waitAccepts(base + 8, 1, 40);
    pend      = '0;
    req_valid = '0;
    for (int k = 0; k < 8 && base + k < acceptLog.size(); k++)
      checkOutput("rr_order", 32'(acceptLog[base+k]), 32'(k % N));
    waitResponses(nRsp + 8, 10);

    $display("[TB] response backpressure");
    resetDut();
    rsp_ready = 1'b0;
    nRsp = rspLog.size();
    present(0, 3'b111, 16'd2, 16'd9);
    waitRspValid(10);
    present(1, 3'b100, 16'h1234, 16'h1234);
    repeat (5) applyStimulus(2);
    rsp_ready = 1'b1;
    waitResponses(nRsp + 1, 5);
    checkRsp("backpressure", nRsp, 0, 16'h0001, 1'b0);
    waitResponses(nRsp + 2, 10);
    checkRsp("after_hold", nRsp + 1, 1, 16'h0000, 1'b1);

    $display("[TB] withdrawn request");
    resetDut();
    rsp_ready = 1'b0;
    base = acceptLog.size();
    nRsp = rspLog.size();
    present(0, 3'b000, 16'd1, 16'd2);
    waitAccepts(base + 1, 2, 10);
    waitRspValid(10);
    present(1, 3'b010, 16'hFFFF, 16'h00FF);
    applyStimulus(2);
    pend[1]   = 1'b0;
    req_valid = pend;
    repeat (2) applyStimulus(2);
    rsp_ready = 1'b1;
    waitResponses(nRsp + 1, 5);
    repeat (5) applyStimulus(2);
    checkOutput("withdrawn_no_grant", 32'(acceptLog.size()), 32'(base + 1));
    checkOutput("withdrawn_idle", 32'(busy), 32'd0);

    $display("[TB] random traffic");
    resetDut();
    repeat (400) applyStimulus(0);
    pend      = '0;
    req_valid = '0;
    rsp_ready = 1'b1;
    t = 0;
    while (expQ.size() > 0 && t < 20) begin
      applyStimulus(2);
      t++;
    end
    checkOutput("drain", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    checkCount++;
    $display("[TB] FAIL watchdog: got timeout, expected bench completion");
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
